// File: rtl/ic74194_seq_pkg.sv
// Shared op-codes, register mode encodings and FSM states for the 74194 sequencer.
package ic74194_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SHR  = 2'd1,
    OP_SHL  = 2'd2,
    OP_ROT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SR   = 2'b01,
    MODE_SL   = 2'b10,
    MODE_LD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Value the attached register takes on the coming edge for a given drive; q is {QA,QB,QC,QD}.
  function automatic logic [3:0] next_q(mode_e mode, logic [3:0] par, logic lin, logic rin,
                                        logic [3:0] q);
    case (mode)
      MODE_SR: return {rin, par[3:1]};
      MODE_SL: return {q[2:0], lin};
      MODE_LD: return par;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/ic74194_seq_if.sv
// Command handshake plus the control/data lines to and from the universal shift register.
interface ic74194_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_fill;
  logic       QA, QB, QC, QD;
  logic       S1, S0;
  logic       A, B, C, D;
  logic       LIN, RIN;
  logic       done;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_cnt, cmd_data, cmd_fill, QA, QB, QC, QD,
    input  cmd_ready, S1, S0, A, B, C, D, LIN, RIN, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_cnt, cmd_data, cmd_fill, QA, QB, QC, QD,
    output cmd_ready, S1, S0, A, B, C, D, LIN, RIN, done
  );
endinterface

// File: rtl/ic74194_seq.sv
// Sequencer that runs LOAD/shift/rotate commands on an external 74194-style register.
module ic74194_seq
  import ic74194_seq_pkg::*;
(
  input logic          clk,
  input logic          CLR,
  ic74194_seq_if.slave bus
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic       dir_q, dir_d;
  logic       fill_q, fill_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] data_q, data_d;
  mode_e      mode_q, mode_d;
  logic [3:0] par_q, par_d;
  logic       lin_q, lin_d;
  logic       rin_q, rin_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [3:0] q_cur, q_nxt;
  logic       accept;

  assign q_cur  = {bus.QA, bus.QB, bus.QC, bus.QD};
  // Outputs are registered, so the next step is derived from the Q the register holds after this edge.
  assign q_nxt  = next_q(mode_q, par_q, lin_q, rin_q, q_cur);
  assign accept = bus.cmd_valid && ready_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = MODE_HOLD;
    par_d   = '0;
    lin_d   = 1'b0;
    rin_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = op_e'(bus.cmd_op);
          dir_d  = bus.cmd_dir;
          fill_d = bus.cmd_fill;
          data_d = bus.cmd_data;
          cnt_d  = (op_d == OP_LOAD) ? 3'd1 : bus.cmd_cnt;
          state_d = (op_d != OP_LOAD && bus.cmd_cnt == 3'd0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) begin
      case (op_d)
        OP_LOAD: begin
          mode_d = MODE_LD;
          par_d  = data_d;
        end
        OP_SHR: begin
          mode_d = MODE_SR;
          par_d  = q_nxt;
          rin_d  = fill_d;
        end
        OP_SHL: begin
          mode_d = MODE_SL;
          par_d  = q_nxt;
          lin_d  = fill_d;
        end
        OP_ROT: begin
          par_d = q_nxt;
          if (dir_d) begin
            mode_d = MODE_SL;
            lin_d  = q_nxt[3];
          end else begin
            mode_d = MODE_SR;
            rin_d  = q_nxt[0];
          end
        end
      endcase
    end

    done_d  = (state_d == ST_FIN);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= MODE_HOLD;
      par_q   <= '0;
      lin_q   <= 1'b0;
      rin_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      lin_q   <= lin_d;
      rin_q   <= rin_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.S1        = mode_q[1];
  assign bus.S0        = mode_q[0];
  assign bus.A         = par_q[3];
  assign bus.B         = par_q[2];
  assign bus.C         = par_q[1];
  assign bus.D         = par_q[0];
  assign bus.LIN       = lin_q;
  assign bus.RIN       = rin_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ic74194_seq.sv
// Bench: sequencer driving a behavioural universal shift register, with a done-driven scoreboard.
module tb_ic74194_seq;

  typedef struct {
    string      tag;
    logic [3:0] q;
    int         lat;
    int         mcyc;
    logic [1:0] mode;
  } exp_t;

  logic clk = 1'b0;
  logic CLR = 1'b1;
  ic74194_seq_if itf();

  ic74194_seq dut (.clk(clk), .CLR(CLR), .bus(itf));

  always #5 clk = ~clk;

  // Register model: right shift takes QB..QD from A..C, left shift takes QD from LIN.
  logic [3:0] reg_q = 4'b0000;
  always @(posedge clk) begin
    case ({itf.S1, itf.S0})
      2'b01:   reg_q <= {itf.RIN, itf.A, itf.B, itf.C};
      2'b10:   reg_q <= {reg_q[2:0], itf.LIN};
      2'b11:   reg_q <= {itf.A, itf.B, itf.C, itf.D};
      default: reg_q <= reg_q;
    endcase
  end
  assign itf.QA = reg_q[3];
  assign itf.QB = reg_q[2];
  assign itf.QC = reg_q[1];
  assign itf.QD = reg_q[0];

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  logic active    = 1'b0;
  bit   ready_chk = 1'b0;
  int   lat_cnt, mode_cnt, bad_mode;
  logic [3:0] ref_q = 4'b0000;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_run(logic [1:0] op, logic dir, logic [2:0] cnt,
                                         logic [3:0] data, logic fill, logic [3:0] q);
    logic [3:0] r;
    r = q;
    if (op == 2'd0) return data;
    for (int unsigned i = 0; i < cnt; i++) begin
      case (op)
        2'd1:    r = {fill, r[3:1]};
        2'd2:    r = {r[2:0], fill};
        default: r = dir ? {r[2:0], r[3]} : {r[0], r[3:1]};
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (ready_chk) begin
      check_val("ready_after_done", itf.cmd_ready, 1);
      ready_chk = 1'b0;
    end
    if (active && sb.size() > 0) begin
      lat_cnt++;
      if ({itf.S1, itf.S0} != 2'b00) begin
        mode_cnt++;
        if ({itf.S1, itf.S0} != sb[0].mode) bad_mode++;
      end
      if (itf.done === 1'b1) begin
        e = sb.pop_front();
        check_val({e.tag, "_q"}, reg_q, e.q);
        check_val({e.tag, "_latency"}, lat_cnt, e.lat);
        check_val({e.tag, "_mode_cycles"}, mode_cnt, e.mcyc);
        check_val({e.tag, "_wrong_mode"}, bad_mode, 0);
        active    = 1'b0;
        ready_chk = 1'b1;
      end
    end else if (itf.done === 1'b1) begin
      check_val("spurious_done", itf.done, 0);
    end
  end

  task automatic issue(string tag, logic [1:0] op, logic dir, logic [2:0] cnt,
                       logic [3:0] data, logic fill);
    exp_t e;
    int waited;
    waited = 0;
    @(negedge clk);
    itf.cmd_op    = op;
    itf.cmd_dir   = dir;
    itf.cmd_cnt   = cnt;
    itf.cmd_data  = data;
    itf.cmd_fill  = fill;
    itf.cmd_valid = 1'b1;
    while (itf.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (itf.cmd_ready !== 1'b1) begin
      check_val({tag, "_accept_timeout"}, 0, 1);
      itf.cmd_valid = 1'b0;
      return;
    end
    ref_q  = ref_run(op, dir, cnt, data, fill, ref_q);
    e.tag  = tag;
    e.q    = ref_q;
    e.lat  = (op == 2'd0) ? 2 : int'(cnt) + 1;
    e.mcyc = (op == 2'd0) ? 1 : int'(cnt);
    e.mode = (op == 2'd0) ? 2'b11 : (op == 2'd1) ? 2'b01 : (op == 2'd2) ? 2'b10 :
             (dir ? 2'b10 : 2'b01);
    sb.push_back(e);
    @(posedge clk);
    #1;
    itf.cmd_valid = 1'b0;
    lat_cnt  = 0;
    mode_cnt = 0;
    bad_mode = 0;
    active   = 1'b1;
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (active && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (active) begin
      check_val({tag, "_done_timeout"}, 0, 1);
      active = 1'b0;
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    itf.cmd_valid = 1'b0;
    itf.cmd_op    = 2'd0;
    itf.cmd_dir   = 1'b0;
    itf.cmd_cnt   = 3'd0;
    itf.cmd_data  = 4'd0;
    itf.cmd_fill  = 1'b0;
    CLR = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ready", itf.cmd_ready, 1);
    check_val("rst_mode", {itf.S1, itf.S0}, 0);
    check_val("rst_par", {itf.A, itf.B, itf.C, itf.D}, 0);
    check_val("rst_serial", {itf.LIN, itf.RIN}, 0);
    check_val("rst_done", itf.done, 0);
    CLR = 1'b0;

    issue("v1_load", 2'd0, 1'b0, 3'd0, 4'b1010, 1'b0); wait_done("v1");
    check_val("v1_q_const", reg_q, 4'b1010);

    issue("v2_load", 2'd0, 1'b0, 3'd0, 4'b1000, 1'b0); wait_done("v2a");
    issue("v2_shr", 2'd1, 1'b0, 3'd2, 4'b0000, 1'b1); wait_done("v2b");
    check_val("v2_q_const", reg_q, 4'b1110);

    issue("v3_load", 2'd0, 1'b0, 3'd0, 4'b0011, 1'b0); wait_done("v3a");
    issue("v3_shl", 2'd2, 1'b0, 3'd3, 4'b1111, 1'b0); wait_done("v3b");
    check_val("v3_q_const", reg_q, 4'b1000);

    issue("v4_load", 2'd0, 1'b0, 3'd0, 4'b1001, 1'b0); wait_done("v4a");
    issue("v4_rotr", 2'd3, 1'b0, 3'd1, 4'b0000, 1'b0); wait_done("v4b");
    check_val("v4_rotr_const", reg_q, 4'b1100);
    issue("v4_rotl4", 2'd3, 1'b1, 3'd4, 4'b0000, 1'b1); wait_done("v4c");
    check_val("v4_rotl4_const", reg_q, 4'b1100);

    issue("v5_shl0", 2'd2, 1'b0, 3'd0, 4'b0000, 1'b1); wait_done("v5");
    check_val("v5_q_const", reg_q, 4'b1100);

    for (int i = 0; i < 10; i++) begin
      issue("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_done("rnd");
    end

    // Abort: busy-time valid must be ignored, CLR must cut the run short with no done.
    issue("v6_load", 2'd0, 1'b0, 3'd0, 4'b0000, 1'b0); wait_done("v6a");
    issue("v6_shr", 2'd1, 1'b0, 3'd7, 4'b0000, 1'b1);
    itf.cmd_op    = 2'd0;
    itf.cmd_data  = 4'b0101;
    itf.cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    CLR           = 1'b1;
    itf.cmd_valid = 1'b0;
    @(negedge clk);
    check_val("v6_mode_after_clr", {itf.S1, itf.S0}, 0);
    check_val("v6_ready_after_clr", itf.cmd_ready, 1);
    check_val("v6_done_after_clr", itf.done, 0);
    check_val("v6_busy_mode_cycles", mode_cnt, 3);
    check_val("v6_busy_wrong_mode", bad_mode, 0);
    check_val("v6_partial_q", reg_q, 4'b1110);
    active = 1'b0;
    sb.delete();
    ref_q = 4'b1110;
    itf.cmd_data  = 4'b1111;
    itf.cmd_valid = 1'b1;
    @(negedge clk);
    check_val("clr_prio_mode", {itf.S1, itf.S0}, 0);
    check_val("clr_prio_ready", itf.cmd_ready, 1);
    CLR           = 1'b0;
    itf.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check_val("v6_q_held", reg_q, 4'b1110);

    issue("post_clr_load", 2'd0, 1'b0, 3'd0, 4'b0110, 1'b0); wait_done("post");
    issue("post_clr_rotr", 2'd3, 1'b0, 3'd2, 4'b0000, 1'b0); wait_done("post2");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
